alt_aeq_adce_ch_ctrl: RTL and testbench

Per-channel adaptation sequencer sitting directly downstream of the full-ADCE calibration controller. It accepts one start or disable request per transaction over the ch_start/ch_disable/ch_busy handshake. It drives the selected channel's ADCE enable and waits for convergence or timeout. It then returns the lf/hf-not-found and conversion-error results that the upstream controller latches when busy falls.

---
 rtl/alt_aeq_pkg.sv | 30 +++
 rtl/alt_aeq_sync2.sv | 27 ++
 rtl/alt_aeq_adce_ch_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_alt_aeq_adce_ch_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alt_aeq_pkg.sv
// Shared definitions for the ADCE adaptation slice: FSM encoding, default
// timing constants and reset values common to this sequencer and the
// upstream calibration controller.
package alt_aeq_pkg;

    localparam int CH_W = 10;

    // Default timing constants
    localparam int DEF_SETTLE_CYCLES  = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1048576;
    localparam int DEF_CNT_W          = 21;

    // Reset values shared with the upstream controller
    localparam logic            RST_BUSY       = 1'b0;
    localparam logic            RST_LF_NF      = 1'b0;
    localparam logic            RST_HF_NF      = 1'b0;
    localparam logic            RST_CONV_ERR   = 1'b0;
    localparam logic            RST_ADCE_EN    = 1'b0;
    localparam logic [CH_W-1:0] RST_CH_ADDR    = '0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESTART = 3'd1,
        ST_ENABLE  = 3'd2,
        ST_ADAPT   = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DISABLE = 3'd5
    } ch_state_t;

endpackage

// File: rtl/alt_aeq_sync2.sv
// Generic 2-flop synchronizer, async active-low reset to 0.
// Latency: 2 i_clock cycles from input change to o_sync_o.
// Backpressure: none; plain level synchronizer.
// Ports: i_clock, i_reset_n, i_async_i (asynchronous level), o_sync_o (synchronized level).
module alt_aeq_sync2 (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_async_i,
    output logic o_sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= i_async_i;
            sync_q <= meta_q;
        end
    end

    assign o_sync_o = sync_q;

endmodule

// File: rtl/alt_aeq_adce_ch_ctrl.sv
// Per-channel ADCE adaptation sequencer: accepts one start/disable request,
// settles the ADCE enable, waits for convergence or timeout, returns results.
// Latency: fresh start reaches ADAPT SETTLE_CYCLES+1 cycles after request; recal adds SETTLE_CYCLES.
// Backpressure: requests are level-held by upstream; ignored while o_busy0q=1.
// Ports: i_ch_start/i_ch_disable/i_logical_ch request in; o_busy0q and result flags out;
//        o_adce_en0q/o_ch_addr0q to transceiver; i_adce_done/lf_sat/hf_sat from ADCE.
// Build option: ALT_AEQ_ADCE_IN_SYNC_EN adds 2-flop synchronizers on the ADCE inputs.
module alt_aeq_adce_ch_ctrl
    import alt_aeq_pkg::*;
#(
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic            i_clock,
    input  logic            i_reset_n,
    input  logic            i_ch_start,
    input  logic            i_ch_disable,
    input  logic [CH_W-1:0] i_logical_ch,
    output logic            o_busy0q,
    output logic            o_lf_not_found0q,
    output logic            o_hf_not_found0q,
    output logic            o_conv_error0q,
    output logic            o_adce_en0q,
    output logic [CH_W-1:0] o_ch_addr0q,
    input  logic            i_adce_done,
    input  logic            i_adce_lf_sat,
    input  logic            i_adce_hf_sat
);

    // A zero settle/timeout would never terminate a phase; clamp to one cycle.
    localparam int SETTLE_EFF  = (SETTLE_CYCLES  < 1) ? 1 : SETTLE_CYCLES;
    localparam int TIMEOUT_EFF = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_EFF - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_EFF - 1);

    logic adce_done_s;
    logic adce_lf_sat_s;
    logic adce_hf_sat_s;

`ifdef ALT_AEQ_ADCE_IN_SYNC_EN
    alt_aeq_sync2 u_sync_done (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_async_i (i_adce_done),
        .o_sync_o  (adce_done_s)
    );
    alt_aeq_sync2 u_sync_lf (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_async_i (i_adce_lf_sat),
        .o_sync_o  (adce_lf_sat_s)
    );
    alt_aeq_sync2 u_sync_hf (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_async_i (i_adce_hf_sat),
        .o_sync_o  (adce_hf_sat_s)
    );
`else
    assign adce_done_s   = i_adce_done;
    assign adce_lf_sat_s = i_adce_lf_sat;
    assign adce_hf_sat_s = i_adce_hf_sat;
`endif

    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    logic             busy_q, busy_d;
    logic             lf_q, lf_d;
    logic             hf_q, hf_d;
    logic             conv_q, conv_d;
    logic             adce_en_q, adce_en_d;
    logic [CH_W-1:0]  ch_addr_q, ch_addr_d;

    logic             settle_done;
    logic [CNT_W-1:0] cnt_inc;

    assign settle_done = (cnt_q == SETTLE_LAST);
    // Saturating increment: the counter must never wrap back to zero.
    assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    // State and output registers
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            busy_q    <= RST_BUSY;
            lf_q      <= RST_LF_NF;
            hf_q      <= RST_HF_NF;
            conv_q    <= RST_CONV_ERR;
            adce_en_q <= RST_ADCE_EN;
            ch_addr_q <= RST_CH_ADDR;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
            lf_q      <= lf_d;
            hf_q      <= hf_d;
            conv_q    <= conv_d;
            adce_en_q <= adce_en_d;
            ch_addr_q <= ch_addr_d;
        end
    end

    // Next-state, counter and timeout flag
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (i_ch_disable || i_ch_start) begin
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    if (i_ch_disable)   state_d = ST_DISABLE;
                    else if (adce_en_q) state_d = ST_RESTART;
                    else                state_d = ST_ENABLE;
                end
            end
            ST_RESTART: begin
                if (settle_done) begin
                    state_d = ST_ENABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_ENABLE: begin
                if (settle_done) begin
                    state_d = ST_ADAPT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_ADAPT: begin
                // Done has priority over a coincident timeout.
                if (adce_done_s) begin
                    state_d   = ST_CAPTURE;
                    timeout_d = 1'b0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = ST_CAPTURE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_CAPTURE: begin
                state_d = ST_IDLE;
            end
            ST_DISABLE: begin
                if (settle_done) state_d = ST_IDLE;
                else             cnt_d   = cnt_inc;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered outputs
    always_comb begin
        busy_d    = busy_q;
        lf_d      = lf_q;
        hf_d      = hf_q;
        conv_d    = conv_q;
        adce_en_d = adce_en_q;
        ch_addr_d = ch_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (i_ch_disable || i_ch_start) begin
                    busy_d    = 1'b1;
                    ch_addr_d = i_logical_ch;
                    lf_d      = 1'b0;
                    hf_d      = 1'b0;
                    conv_d    = 1'b0;
                    // Only a fresh start raises the enable now; recal first drops it.
                    adce_en_d = !i_ch_disable && !adce_en_q;
                end
            end
            ST_RESTART: begin
                adce_en_d = settle_done;
            end
            ST_ENABLE: begin
                adce_en_d = 1'b1;
            end
            ST_CAPTURE: begin
                lf_d   = adce_lf_sat_s;
                hf_d   = adce_hf_sat_s;
                conv_d = timeout_q;
                busy_d = 1'b0;
            end
            ST_DISABLE: begin
                adce_en_d = 1'b0;
                if (settle_done) busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign o_busy0q         = busy_q;
    assign o_lf_not_found0q = lf_q;
    assign o_hf_not_found0q = hf_q;
    assign o_conv_error0q   = conv_q;
    assign o_adce_en0q      = adce_en_q;
    assign o_ch_addr0q      = ch_addr_q;

endmodule

// File: tb/tb_alt_aeq_adce_ch_ctrl.sv
// Directed bench for alt_aeq_adce_ch_ctrl with SETTLE_CYCLES=4, TIMEOUT_CYCLES=32.
// Inputs driven and outputs sampled on the falling clock edge.
// Busy length n counts falling edges from request raise until busy is seen low.
module tb_alt_aeq_adce_ch_ctrl;

    logic       i_clock = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_ch_start = 1'b0;
    logic       i_ch_disable = 1'b0;
    logic [9:0] i_logical_ch = '0;
    logic       o_busy0q, o_lf_not_found0q, o_hf_not_found0q, o_conv_error0q, o_adce_en0q;
    logic [9:0] o_ch_addr0q;
    logic       i_adce_done = 1'b0;
    logic       i_adce_lf_sat = 1'b0;
    logic       i_adce_hf_sat = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 i_clock = ~i_clock;

    alt_aeq_adce_ch_ctrl #(
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (32),
        .CNT_W          (21)
    ) dut (
        .i_clock          (i_clock),
        .i_reset_n        (i_reset_n),
        .i_ch_start       (i_ch_start),
        .i_ch_disable     (i_ch_disable),
        .i_logical_ch     (i_logical_ch),
        .o_busy0q         (o_busy0q),
        .o_lf_not_found0q (o_lf_not_found0q),
        .o_hf_not_found0q (o_hf_not_found0q),
        .o_conv_error0q   (o_conv_error0q),
        .o_adce_en0q      (o_adce_en0q),
        .o_ch_addr0q      (o_ch_addr0q),
        .i_adce_done      (i_adce_done),
        .i_adce_lf_sat    (i_adce_lf_sat),
        .i_adce_hf_sat    (i_adce_hf_sat)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Issue one request and run until busy falls. done_at: cycle at which
    // i_adce_done is raised (0 = never). pulse_at: cycle at which a one-cycle
    // start (ch 9) is pulsed while busy (0 = never).
    task automatic run_req(input logic st, input logic dis, input logic [9:0] ch,
                           input int done_at, input int pulse_at,
                           output int n, output int en_low);
        i_ch_start   = st;
        i_ch_disable = dis;
        i_logical_ch = ch;
        n      = 0;
        en_low = 0;
        do begin
            @(negedge i_clock);
            n++;
            if (n == 1) begin
                i_ch_start   = 1'b0;
                i_ch_disable = 1'b0;
                i_logical_ch = 10'h3ff;
            end
            if (o_busy0q && !o_adce_en0q) en_low++;
            if (n == done_at) i_adce_done = 1'b1;
            if (pulse_at != 0 && n == pulse_at) begin
                i_ch_start   = 1'b1;
                i_logical_ch = 10'd9;
            end
            if (pulse_at != 0 && n == pulse_at + 1) i_ch_start = 1'b0;
        end while (o_busy0q && n < 400);
        if (n >= 400) chk("busy_bound", 32'd1, 32'd0);
        i_adce_done = 1'b0;
    endtask

    int n, en_low;

    initial begin
        // Reset state
        #3;
        chk("rst_busy", o_busy0q, 0);
        chk("rst_lf",   o_lf_not_found0q, 0);
        chk("rst_hf",   o_hf_not_found0q, 0);
        chk("rst_conv", o_conv_error0q, 0);
        chk("rst_en",   o_adce_en0q, 0);
        chk("rst_addr", o_ch_addr0q, 0);
        repeat (2) @(negedge i_clock);
        i_reset_n = 1'b1;
        @(negedge i_clock);

        // Fresh start, done in 10th ADAPT cycle, lf_sat=1: busy 1+4+10+1
        i_adce_lf_sat = 1'b1;
        i_adce_hf_sat = 1'b0;
        run_req(1'b1, 1'b0, 10'd5, 14, 0, n, en_low);
        chk("fresh_len",  n, 16);
        chk("fresh_lf",   o_lf_not_found0q, 1);
        chk("fresh_hf",   o_hf_not_found0q, 0);
        chk("fresh_conv", o_conv_error0q, 0);
        chk("fresh_en",   o_adce_en0q, 1);
        chk("fresh_enlo", en_low, 0);
        chk("fresh_addr", o_ch_addr0q, 5);
        i_adce_lf_sat = 1'b0;
        repeat (3) @(negedge i_clock);
        chk("hold_lf",    o_lf_not_found0q, 1);
        chk("hold_busy",  o_busy0q, 0);

        // Recal: enable low 4, high 4, then ADAPT; done after 4 ADAPT cycles
        run_req(1'b1, 1'b0, 10'd3, 12, 0, n, en_low);
        chk("recal_len",  n, 14);
        chk("recal_enlo", en_low, 4);
        chk("recal_addr", o_ch_addr0q, 3);
        chk("recal_lf",   o_lf_not_found0q, 0);
        chk("recal_en",   o_adce_en0q, 1);

        // Start and disable together: disable wins, flags stay 0
        i_adce_lf_sat = 1'b1;
        i_adce_hf_sat = 1'b1;
        run_req(1'b1, 1'b1, 10'd7, 2, 0, n, en_low);
        chk("dis_len",  n, 5);
        chk("dis_enlo", en_low, 4);
        chk("dis_en",   o_adce_en0q, 0);
        chk("dis_lf",   o_lf_not_found0q, 0);
        chk("dis_hf",   o_hf_not_found0q, 0);
        chk("dis_conv", o_conv_error0q, 0);
        chk("dis_addr", o_ch_addr0q, 7);

        // Fresh start, no done: timeout after exactly 32 ADAPT cycles
        i_adce_lf_sat = 1'b0;
        i_adce_hf_sat = 1'b1;
        run_req(1'b1, 1'b0, 10'd12, 0, 0, n, en_low);
        chk("to_len",  n, 38);
        chk("to_conv", o_conv_error0q, 1);
        chk("to_lf",   o_lf_not_found0q, 0);
        chk("to_hf",   o_hf_not_found0q, 1);
        i_adce_hf_sat = 1'b0;

        // Reset mid-ADAPT (recal, ADAPT begins after 9th edge)
        i_ch_start   = 1'b1;
        i_logical_ch = 10'd21;
        @(negedge i_clock);
        i_ch_start = 1'b0;
        repeat (11) @(negedge i_clock);
        chk("mid_busy_pre", o_busy0q, 1);
        #2 i_reset_n = 1'b0;
        #1;
        chk("mrst_busy", o_busy0q, 0);
        chk("mrst_en",   o_adce_en0q, 0);
        chk("mrst_addr", o_ch_addr0q, 0);
        chk("mrst_conv", o_conv_error0q, 0);
        @(negedge i_clock);
        i_reset_n = 1'b1;
        @(negedge i_clock);

        // After reset the start is fresh again
        i_adce_lf_sat = 1'b0;
        i_adce_hf_sat = 1'b1;
        run_req(1'b1, 1'b0, 10'd2, 14, 0, n, en_low);
        chk("post_len",  n, 16);
        chk("post_enlo", en_low, 0);
        chk("post_hf",   o_hf_not_found0q, 1);
        chk("post_addr", o_ch_addr0q, 2);
        i_adce_hf_sat = 1'b0;

        // Done coincident with timeout (recal: last ADAPT cycle is n=40), start pulsed while busy
        run_req(1'b1, 1'b0, 10'd4, 40, 20, n, en_low);
        chk("coin_len",  n, 42);
        chk("coin_conv", o_conv_error0q, 0);
        chk("coin_addr", o_ch_addr0q, 4);
        repeat (3) @(negedge i_clock);
        chk("coin_idle", o_busy0q, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
